// File: rtl/joystick_pkg.sv
// joystick_pkg: shared constants and state types for the joystick ADC scanner
package joystick_pkg;
  localparam int ADC_BITS = 10;
  localparam int FRAME_SCLKS = 17;
  localparam int FIRST_DATA_SCLK = 8;
  localparam logic [ADC_BITS-1:0] ADC_MIDSCALE = 10'd512;
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, PUBLISH} state_t;
  typedef enum logic [1:0] {SCAN_IDLE, SCAN_FRAME, SCAN_PUBLISH} scan_t;
  typedef enum logic {AXIS_X, AXIS_Y} axis_t;
endpackage

// File: rtl/adc_spi_frame.sv
// adc_spi_frame: one 17-SCLK MCP3008 single-ended conversion (setup, shift, CS hold)
module adc_spi_frame
  import joystick_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [2:0]          i_ch,
  input  logic                i_miso,
  output logic                o_done,
  output logic [ADC_BITS-1:0] o_result,
  output logic                o_sclk,
  output logic                o_cs_n,
  output logic                o_mosi
);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] HALF_END = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] PER_END = DW'(2 * CLK_DIV - 1);
  localparam logic [4:0] LAST_SCLK = 5'(FRAME_SCLKS - 1);
  localparam logic [4:0] FIRST_DATA = 5'(FIRST_DATA_SCLK - 1);
  state_t r_state, w_next;
  logic [DW-1:0] r_div;
  logic [4:0] r_sclk_n;
  logic [2:0] r_ch;
  logic [ADC_BITS-1:0] r_shift;
  logic [4:0] w_cmd;
  logic w_phase_end, w_rise;
  assign w_phase_end = r_div == ((r_state == CS_SETUP) ? HALF_END : PER_END);
  assign w_rise = r_state == SHIFT && r_div == HALF_END;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_div <= '0;
      r_sclk_n <= '0;
    end else begin
      r_state <= w_next;
      r_div <= (r_state == IDLE || w_phase_end) ? '0 : r_div + 1'b1;
      r_sclk_n <= (r_state == SHIFT) ? r_sclk_n + 5'(w_phase_end) : '0;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = i_start ? CS_SETUP : IDLE;
      CS_SETUP: w_next = w_phase_end ? SHIFT : CS_SETUP;
      SHIFT:    w_next = (w_phase_end && r_sclk_n == LAST_SCLK) ? CS_HOLD : SHIFT;
      CS_HOLD:  w_next = w_phase_end ? (i_start ? CS_SETUP : IDLE) : CS_HOLD;
      default:  w_next = IDLE;
    endcase
  end
  // The leading 7 SCLKs carry command, sample and null bits; only the last 10 hold data
  always_ff @(posedge clk) begin
    if (i_start) r_ch <= i_ch;
    if (w_rise && r_sclk_n >= FIRST_DATA) r_shift <= {r_shift[ADC_BITS-2:0], i_miso};
  end
  always_comb begin
    w_cmd = {2'b11, r_ch};
    o_cs_n = !(r_state == CS_SETUP || r_state == SHIFT);
    o_sclk = r_state == SHIFT && r_div > HALF_END;
    o_mosi = r_state == SHIFT && r_sclk_n < 5'd5 && w_cmd[3'(4 - r_sclk_n)];
    o_done = r_state == CS_HOLD && w_phase_end;
    o_result = r_shift;
  end
endmodule

// File: rtl/joystick_adc_scanner.sv
// joystick_adc_scanner: periodic X/Y scan of an SPI ADC with atomic publish of both axes
module joystick_adc_scanner
  import joystick_pkg::*;
#(
  parameter int         CLK_DIV = 50,
  parameter int         SCAN_PERIOD = 100000,
  parameter logic [2:0] X_CH = 3'd0,
  parameter logic [2:0] Y_CH = 3'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       adc_miso,
  output logic       adc_sclk,
  output logic       adc_cs_n,
  output logic       adc_mosi,
  output logic [9:0] x_axis_out,
  output logic [9:0] y_axis_out,
  output logic       sample_valid,
  output logic       busy
);
  localparam int PW = $clog2(SCAN_PERIOD);
  localparam logic [PW-1:0] PER_END = PW'(SCAN_PERIOD - 1);
  scan_t r_state, w_next;
  axis_t r_axis;
  logic [PW-1:0] r_per;
  logic [ADC_BITS-1:0] r_x_tmp, r_x, r_y, w_result;
  logic w_tick, w_start, w_done;
  logic [2:0] w_ch;
  assign w_tick = enable && r_per == PER_END;
  assign w_start = (r_state == SCAN_IDLE && w_tick) || (w_done && r_axis == AXIS_X);
  assign w_ch = (r_state == SCAN_IDLE) ? X_CH : Y_CH;
  adc_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
    .clk(clk),
    .rst(rst),
    .i_start(w_start),
    .i_ch(w_ch),
    .i_miso(adc_miso),
    .o_done(w_done),
    .o_result(w_result),
    .o_sclk(adc_sclk),
    .o_cs_n(adc_cs_n),
    .o_mosi(adc_mosi)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SCAN_IDLE;
      r_per <= '0;
    end else begin
      r_state <= w_next;
      r_per <= (!enable || r_per == PER_END) ? '0 : r_per + 1'b1;
    end
  end
  always_comb
    w_next = (r_state == SCAN_IDLE) ? (w_tick ? SCAN_FRAME : SCAN_IDLE) :
             (r_state == SCAN_FRAME) ? ((w_done && r_axis == AXIS_Y) ? SCAN_PUBLISH : SCAN_FRAME) :
             SCAN_IDLE;
  // X is parked until Y completes so the outputs never show a mixed pair
  always_ff @(posedge clk) begin
    if (rst) begin
      r_axis <= AXIS_X;
      r_x_tmp <= ADC_MIDSCALE;
      r_x <= ADC_MIDSCALE;
      r_y <= ADC_MIDSCALE;
    end else begin
      r_axis <= (r_state == SCAN_IDLE) ? AXIS_X : (w_done ? AXIS_Y : r_axis);
      if (w_done && r_axis == AXIS_X) r_x_tmp <= w_result;
      if (w_done && r_axis == AXIS_Y) begin
        r_x <= r_x_tmp;
        r_y <= w_result;
      end
    end
  end
  always_comb begin
    sample_valid = r_state == SCAN_PUBLISH;
    busy = r_state != SCAN_IDLE;
    x_axis_out = r_x;
    y_axis_out = r_y;
  end
endmodule

// File: tb/tb_joystick_adc_scanner.sv
// tb_joystick_adc_scanner: directed scan sequence against a behavioural MCP3008 model
module tb_joystick_adc_scanner;
  localparam int D = 3;
  localparam int P = 300;
  localparam logic [2:0] XC = 3'd5;
  localparam logic [2:0] YC = 3'd2;
  localparam int HT = D * 10;
  localparam int LAT = (P - 1) + (74 * D + 1);
  logic clk = 0, rst = 1, enable = 0, adc_miso = 0;
  logic adc_sclk, adc_cs_n, adc_mosi, sample_valid, busy;
  logic [9:0] x_axis_out, y_axis_out;
  int checks = 0, errors = 0;
  logic [9:0] adc_val [8];
  logic [9:0] cur_x = 10'd512, cur_y = 10'd512;
  time t_pub = 0;
  typedef struct {int rises; logic [4:0] cmd; int bad;} frame_t;
  frame_t frames[$];
  int cur_rises = 0, cur_bad = 0, cs_falls = 0;
  logic [4:0] cur_cmd = '0;
  logic [9:0] cur_word = '0;
  time t_rise = 0, t_fall = 0;

  joystick_adc_scanner #(.CLK_DIV(D), .SCAN_PERIOD(P), .X_CH(XC), .Y_CH(YC)) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_miso(adc_miso),
    .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .adc_mosi(adc_mosi),
    .x_axis_out(x_axis_out), .y_axis_out(y_axis_out),
    .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // ADC model: latches command on SCLK rises, shifts B9..B0 out on falls after rise 7
  always @(negedge adc_cs_n) begin
    cs_falls++;
    cur_rises = 0;
    cur_cmd = '0;
    cur_bad = 0;
  end
  always @(posedge adc_cs_n) begin
    #1;
    frames.push_back('{cur_rises, cur_cmd, cur_bad});
  end
  always @(posedge adc_sclk) if (!adc_cs_n) begin
    cur_rises++;
    if (cur_rises <= 5) cur_cmd = {cur_cmd[3:0], adc_mosi};
    if (cur_rises == 5) cur_word = adc_val[cur_cmd[2:0]];
    if (cur_rises > 1 && int'($time - t_fall) != HT) cur_bad++;
    t_rise = $time;
  end
  always @(negedge adc_sclk) begin
    if (int'($time - t_rise) != HT) cur_bad++;
    t_fall = $time;
    adc_miso = (cur_rises >= 7 && cur_rises <= 16) ? cur_word[4'(16 - cur_rises)] : 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_vals();
    foreach (adc_val[i]) adc_val[i] = 10'($urandom_range(0, 1023));
  endtask

  task automatic wait_valid(input int bound, output int n, output int hb);
    n = 0;
    hb = 0;
    while (n < bound) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (sample_valid) break;
      if (x_axis_out !== cur_x || y_axis_out !== cur_y) hb++;
    end
  endtask

  task automatic scan(input string tag, input int exp_lat, input int exp_per);
    int n, hb;
    time t;
    wait_valid(2 * P + LAT, n, hb);
    t = $time;
    check({tag, " valid"}, sample_valid, 1);
    if (exp_lat > 0) check({tag, " latency"}, n, exp_lat);
    if (exp_per > 0) check({tag, " period"}, int'((t - t_pub) / 10), exp_per);
    t_pub = t;
    check({tag, " x"}, x_axis_out, adc_val[XC]);
    check({tag, " y"}, y_axis_out, adc_val[YC]);
    check({tag, " hold"}, hb, 0);
    check({tag, " busy pub"}, busy, 1);
    cur_x = adc_val[XC];
    cur_y = adc_val[YC];
    check({tag, " frames"}, frames.size(), 2);
    foreach (frames[i]) begin
      check({tag, " rises"}, frames[i].rises, 17);
      check({tag, " cmd"}, frames[i].cmd, (i == 0) ? {2'b11, XC} : {2'b11, YC});
      check({tag, " halves"}, frames[i].bad, 0);
    end
    frames.delete();
    @(negedge clk);
    check({tag, " pulse end"}, sample_valid, 0);
    check({tag, " busy end"}, busy, 0);
    check({tag, " x held"}, x_axis_out, cur_x);
    check({tag, " y held"}, y_axis_out, cur_y);
  endtask

  initial begin
    int base, k, svc;
    rst = 1;
    enable = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst cs_n", adc_cs_n, 1);
    check("rst sclk", adc_sclk, 0);
    check("rst mosi", adc_mosi, 0);
    check("rst x", x_axis_out, 512);
    check("rst y", y_axis_out, 512);
    check("rst valid", sample_valid, 0);
    check("rst busy", busy, 0);
    rst = 0;
    frames.delete();
    base = cs_falls;
    svc = 0;
    repeat (3 * P) begin
      @(negedge clk);
      if (sample_valid) svc++;
    end
    check("disabled cs activity", cs_falls - base, 0);
    check("disabled valid", svc, 0);
    check("disabled x", x_axis_out, 512);
    set_vals();
    enable = 1;
    scan("scan1", LAT, 0);
    set_vals();
    scan("scan2", 0, P);
    adc_val[XC] = 10'd0;
    adc_val[YC] = 10'd1023;
    scan("bound lo/hi", 0, P);
    adc_val[XC] = 10'd1023;
    adc_val[YC] = 10'd0;
    scan("bound hi/lo", 0, P);
    set_vals();
    base = cs_falls;
    k = 0;
    while (cs_falls < base + 2 && k < 2 * P) begin
      @(negedge clk);
      k++;
    end
    check("y frame start", cs_falls - base, 2);
    enable = 0;
    scan("late disable", 0, P);
    base = cs_falls;
    svc = 0;
    repeat (2 * P) begin
      @(negedge clk);
      if (sample_valid) svc++;
    end
    check("after disable cs", cs_falls - base, 0);
    check("after disable valid", svc, 0);
    set_vals();
    enable = 1;
    base = cs_falls;
    k = 0;
    while ((cs_falls == base || cur_rises < 3) && k < 2 * P) begin
      @(negedge clk);
      k++;
    end
    check("x shift reached", cur_rises >= 3, 1);
    rst = 1;
    @(posedge clk);
    #1;
    check("midrst cs_n", adc_cs_n, 1);
    check("midrst sclk", adc_sclk, 0);
    check("midrst x", x_axis_out, 512);
    check("midrst y", y_axis_out, 512);
    check("midrst busy", busy, 0);
    check("midrst valid", sample_valid, 0);
    @(negedge clk);
    rst = 0;
    frames.delete();
    cur_x = 10'd512;
    cur_y = 10'd512;
    scan("after rst", LAT, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
